// File: rtl/avl_stream_pkt_arb.sv
// avl_stream_pkt_arb
// Two-input Avalon-ST packet arbiter. It grants whole packets round-robin and
// drives them through one output register stage. In IDLE it drops stray
// non-sop beats (orphans) and counts them in a saturating 16-bit err_cnt.
//
// Optional feature: define AVL_STREAM_PKT_ARB_CHTAG_EN to tag out_channel
// with the source input index instead of passing inN_channel through.
module avl_stream_pkt_arb #(
    parameter int WIDTH = 512,
    parameter int NUM   = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_sop,
    input  logic             in0_eop,
    input  logic [5:0]       in0_empty,
    input  logic [NUM-1:0]   in0_channel,
    output logic             in0_ready,

    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_sop,
    input  logic             in1_eop,
    input  logic [5:0]       in1_empty,
    input  logic [NUM-1:0]   in1_channel,
    output logic             in1_ready,

    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [5:0]       out_empty,
    output logic [NUM-1:0]   out_channel,
    input  logic             out_ready,
    input  logic             out_almost_full,

    output logic [15:0]      err_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           last_grant;
    logic           rdy0;
    logic           rdy1;
    logic           req0;
    logic           req1;
    logic           orph0;
    logic           orph1;
    logic           out_free;
    logic           fwd0;
    logic           fwd1;
    logic [1:0]     orph_inc;
    logic [16:0]    err_sum;
    logic [NUM-1:0] ch0;
    logic [NUM-1:0] ch1;

    assign req0  = in0_valid &&  in0_sop;
    assign req1  = in1_valid &&  in1_sop;
    assign orph0 = in0_valid && !in0_sop;
    assign orph1 = in1_valid && !in1_sop;

    // The output register can take a beat when it is empty or being drained.
    assign out_free = !out_valid || out_ready;

    // Beats actually forwarded from the granted input this cycle.
    assign fwd0 = (state == GNT0) && in0_valid && out_free;
    assign fwd1 = (state == GNT1) && in1_valid && out_free;

    // Orphans only exist in IDLE; two at once count double.
    assign orph_inc = (state == IDLE) ? ({1'b0, orph0} + {1'b0, orph1}) : 2'd0;
    assign err_sum  = {1'b0, err_cnt} + {15'd0, orph_inc};

`ifdef AVL_STREAM_PKT_ARB_CHTAG_EN
    logic unused_channel;
    assign unused_channel = ^{in0_channel, in1_channel};
    assign ch0 = NUM'(0);
    assign ch1 = NUM'(1);
`else
    assign ch0 = in0_channel;
    assign ch1 = in1_channel;
`endif

    // Ready decode: the granted input follows output space, orphans drain in IDLE.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        case (state)
            IDLE: begin
                rdy0 = orph0;
                rdy1 = orph1;
            end
            GNT0:    rdy0 = out_free;
            GNT1:    rdy1 = out_free;
            default: ;
        endcase
    end

    // Readies are forced low while reset is held, even for orphans.
    assign in0_ready = !rst && rdy0;
    assign in1_ready = !rst && rdy1;

    // Next-state decode: grant new packets in IDLE, release on accepted eop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!out_almost_full) begin
                    if (req0 && req1)
                        state_nxt = last_grant ? GNT0 : GNT1;
                    else if (req0)
                        state_nxt = GNT0;
                    else if (req1)
                        state_nxt = GNT1;
                end
            end
            GNT0:    if (fwd0 && in0_eop) state_nxt = IDLE;
            GNT1:    if (fwd1 && in1_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, round-robin pointer and saturating orphan counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            err_cnt    <= 16'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (fwd0 && in0_eop)
                last_grant <= 1'b0;
            else if (fwd1 && in1_eop)
                last_grant <= 1'b1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    // Single output register stage; holds its contents while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data path is reset too because the outputs must read zero during reset.
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_data    <= '0;
            out_empty   <= 6'd0;
            out_channel <= '0;
        end else if (out_free) begin
            out_valid <= fwd0 || fwd1;
            if (fwd0) begin
                out_data    <= in0_data;
                out_sop     <= in0_sop;
                out_eop     <= in0_eop;
                out_empty   <= in0_empty;
                out_channel <= ch0;
            end else if (fwd1) begin
                out_data    <= in1_data;
                out_sop     <= in1_sop;
                out_eop     <= in1_eop;
                out_empty   <= in1_empty;
                out_channel <= ch1;
            end
        end
    end

endmodule

// File: tb/tb_avl_stream_pkt_arb.sv
// tb_avl_stream_pkt_arb
// Directed bench for avl_stream_pkt_arb with hand-computed expectations.
// Expected out_channel follows AVL_STREAM_PKT_ARB_CHTAG_EN when defined.
module tb_avl_stream_pkt_arb;

    localparam int WIDTH = 32;
    localparam int NUM   = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in0_data, in1_data, out_data;
    logic             in0_valid, in0_sop, in0_eop, in0_ready;
    logic             in1_valid, in1_sop, in1_eop, in1_ready;
    logic [5:0]       in0_empty, in1_empty, out_empty;
    logic [NUM-1:0]   in0_channel, in1_channel, out_channel;
    logic             out_valid, out_sop, out_eop, out_ready, out_almost_full;
    logic [15:0]      err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    avl_stream_pkt_arb #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop), .in0_eop(in0_eop),
        .in0_empty(in0_empty), .in0_channel(in0_channel), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop), .in1_eop(in1_eop),
        .in1_empty(in1_empty), .in1_channel(in1_channel), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_channel(out_channel), .out_ready(out_ready),
        .out_almost_full(out_almost_full), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sink with a beat, then let combinational readies settle.
    task automatic drv(input int n, input logic v, input logic s, input logic e,
                       input logic [5:0] emp, input logic [WIDTH-1:0] d);
        if (n == 0) begin
            in0_valid = v; in0_sop = s; in0_eop = e; in0_empty = emp; in0_data = d;
        end else begin
            in1_valid = v; in1_sop = s; in1_eop = e; in1_empty = emp; in1_data = d;
        end
        #1;
    endtask

    function automatic logic [NUM-1:0] exp_ch(input int src);
`ifdef AVL_STREAM_PKT_ARB_CHTAG_EN
        return (src == 1) ? NUM'(1) : NUM'(0);
`else
        return (src == 1) ? NUM'(3) : NUM'(2);
`endif
    endfunction

    initial begin
        int src;
        logic [WIDTH-1:0] exp_d;

        rst = 1'b1;
        out_ready = 1'b1;
        out_almost_full = 1'b0;
        in0_channel = 2'd2;
        in1_channel = 2'd3;
        drv(0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);  // orphan-looking beat held during reset
        drv(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);

        // Reset state
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sop_eop", {out_sop, out_eop}, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in0_ready", in0_ready, 0);
        check("rst_in1_ready", in1_ready, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        tick();
        rst = 1'b0;

        // Single in0 3-beat packet
        drv(0, 1'b1, 1'b1, 1'b0, 6'd0, 32'hD000_0000);
        check("s1_idle_ready", in0_ready, 0);
        tick();
        check("s1_gnt_ready", in0_ready, 1);
        check("s1_gnt_in1_ready", in1_ready, 0);
        tick();
        check("s1_b0_data", out_data, 32'hD000_0000);
        check("s1_b0_flags", {out_valid, out_sop, out_eop}, 3'b110);
        check("s1_b0_ch", out_channel, exp_ch(0));
        drv(0, 1'b1, 1'b0, 1'b0, 6'd0, 32'hD000_0001);
        tick();
        check("s1_b1_data", out_data, 32'hD000_0001);
        check("s1_b1_flags", {out_valid, out_sop, out_eop}, 3'b100);
        drv(0, 1'b1, 1'b0, 1'b1, 6'd5, 32'hD000_0002);
        tick();
        check("s1_b2_data", out_data, 32'hD000_0002);
        check("s1_b2_flags", {out_valid, out_sop, out_eop}, 3'b101);
        check("s1_b2_empty", out_empty, 5);
        drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        tick();
        check("s1_drained", out_valid, 0);

        // Round-robin after a fresh reset: grants 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv(0, 1'b1, 1'b1, 1'b1, 6'd0, 32'hA000_0000);
        drv(1, 1'b1, 1'b1, 1'b1, 6'd0, 32'hB000_0001);
        for (int k = 0; k < 4; k++) begin
            src = k % 2;
            exp_d = ((src == 1) ? 32'hB000_0000 : 32'hA000_0000) + 32'(k);
            tick();
            check($sformatf("rr%0d_ready0", k), in0_ready, (src == 0));
            check($sformatf("rr%0d_ready1", k), in1_ready, (src == 1));
            tick();
            check($sformatf("rr%0d_data", k), out_data, exp_d);
            check($sformatf("rr%0d_flags", k), {out_valid, out_sop, out_eop}, 3'b111);
            check($sformatf("rr%0d_ch", k), out_channel, exp_ch(src));
            drv(src, 1'b1, 1'b1, 1'b1, 6'd0, exp_d + 32'd2);
        end
        drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        tick();
        check("rr_drained", out_valid, 0);

        // in1 4-beat packet with out_ready toggled 1,0,0,1
        drv(1, 1'b1, 1'b1, 1'b0, 6'd0, 32'hC000_0000);
        tick();
        check("s3_gnt_ready1", in1_ready, 1);
        drv(0, 1'b1, 1'b1, 1'b0, 6'd0, 32'hE000_0000);
        check("s3_ready0_a", in0_ready, 0);
        tick();
        check("s3_c0", out_data, 32'hC000_0000);
        check("s3_c0_sop", out_sop, 1);
        drv(1, 1'b1, 1'b0, 1'b0, 6'd0, 32'hC000_0001);
        tick();
        check("s3_c1", out_data, 32'hC000_0001);
        check("s3_ready0_b", in0_ready, 0);
        drv(1, 1'b1, 1'b0, 1'b0, 6'd0, 32'hC000_0002);
        out_ready = 1'b0;
        #1;
        check("s3_stall_ready1", in1_ready, 0);
        tick();
        check("s3_hold1_data", out_data, 32'hC000_0001);
        check("s3_hold1_valid", out_valid, 1);
        check("s3_ready0_c", in0_ready, 0);
        tick();
        check("s3_hold2_data", out_data, 32'hC000_0001);
        check("s3_hold2_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("s3_resume_ready1", in1_ready, 1);
        tick();
        check("s3_c2", out_data, 32'hC000_0002);
        drv(1, 1'b1, 1'b0, 1'b1, 6'd3, 32'hC000_0003);
        tick();
        check("s3_c3", out_data, 32'hC000_0003);
        check("s3_c3_eop_empty", {out_eop, out_empty}, {1'b1, 6'd3});
        check("s3_c3_ch", out_channel, exp_ch(1));
        check("s3_ready0_d", in0_ready, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        tick();
        check("s3_drained", out_valid, 0);

        // almost_full blocks a new grant but not a packet in flight
        out_almost_full = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b0, 6'd0, 32'hF000_0000);
        check("s4_af_ready_a", in0_ready, 0);
        tick();
        check("s4_af_ready_b", in0_ready, 0);
        tick();
        check("s4_af_ready_c", in0_ready, 0);
        check("s4_af_no_out", out_valid, 0);
        out_almost_full = 1'b0;
        tick();
        check("s4_gnt_ready", in0_ready, 1);
        out_almost_full = 1'b1;
        tick();
        check("s4_f0", out_data, 32'hF000_0000);
        drv(0, 1'b1, 1'b0, 1'b0, 6'd0, 32'hF000_0001);
        tick();
        check("s4_f1", out_data, 32'hF000_0001);
        drv(0, 1'b1, 1'b0, 1'b1, 6'd0, 32'hF000_0002);
        tick();
        check("s4_f2", out_data, 32'hF000_0002);
        check("s4_f2_eop", {out_valid, out_eop}, 2'b11);
        drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        out_almost_full = 1'b0;
        tick();
        check("s4_drained", out_valid, 0);

        // Orphans: dual orphans count by 2, counter saturates at FFFF
        drv(0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0BAD_0000);
        drv(1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0BAD_0001);
        check("s5_orph_ready0", in0_ready, 1);
        check("s5_orph_ready1", in1_ready, 1);
        tick();
        check("s5_err_2", err_cnt, 16'd2);
        repeat (32766) tick();
        check("s5_err_fffe", err_cnt, 16'hFFFE);
        check("s5_no_forward", out_valid, 0);
        drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        check("s5_single_ready0", in0_ready, 0);
        check("s5_single_ready1", in1_ready, 1);
        tick();
        check("s5_err_ffff", err_cnt, 16'hFFFF);
        tick();
        check("s5_err_sat", err_cnt, 16'hFFFF);
        check("s5_no_forward_b", out_valid, 0);
        drv(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);

        // Reset in the middle of an in1 5-beat packet
        drv(1, 1'b1, 1'b1, 1'b0, 6'd0, 32'h6000_0000);
        tick();
        tick();
        check("s6_g0", out_data, 32'h6000_0000);
        check("s6_g0_ch", out_channel, exp_ch(1));
        drv(1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h6000_0001);
        tick();
        check("s6_g1", out_data, 32'h6000_0001);
        drv(1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h6000_0002);
        rst = 1'b1;
        #1;
        check("s6_async_valid", out_valid, 0);
        check("s6_async_data", out_data, 0);
        check("s6_async_misc", {out_sop, out_eop, out_empty, out_channel}, 0);
        check("s6_async_err", err_cnt, 0);
        check("s6_async_ready1", in1_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("s6_post_orphan_ready", in1_ready, 1);
        tick();
        check("s6_post_err", err_cnt, 16'd1);
        check("s6_post_no_out", out_valid, 0);
        drv(1, 1'b1, 1'b1, 1'b1, 6'd0, 32'h7000_0000);
        tick();
        tick();
        check("s6_new_sop", {out_valid, out_sop, out_eop}, 3'b111);
        check("s6_new_data", out_data, 32'h7000_0000);
        check("s6_new_ch", out_channel, exp_ch(1));
        drv(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
        tick();
        check("s6_drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/avl_stream_pkt_arb.md
AVL_STREAM_PKT_ARB -- requirements
Module: avl_stream_pkt_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 512: data width in bits, for all ports.
REQ-002 SHALL have parameter NUM, default 2: channel width in bits.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports inN_data/inN_valid/inN_sop/inN_eop/inN_empty/inN_channel, input, WIDTH/1/1/1/6/NUM: Avalon-ST sink N, where N = 0,1.
REQ-006 SHALL have port inN_ready, output, 1: sink N accepts a beat when inN_valid && inN_ready.
REQ-007 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty/out_channel, output, WIDTH/1/1/1/6/NUM: Avalon-ST source.
REQ-008 SHALL have port out_ready, input, 1: downstream accepts a beat when out_valid && out_ready.
REQ-009 SHALL have port out_almost_full, input, 1: downstream backpressure hint; blocks new packet grants only.
REQ-010 SHALL have port err_cnt, output, 16: saturating count of orphan beats dropped.

Function
REQ-011 SHALL arbitrate whole packets: once a packet is granted, no beat from the other input appears on out_* until the granted packet's eop beat has been accepted.
REQ-012 SHALL implement an FSM with states IDLE, GNT0 and GNT1.
REQ-013 IDLE SHALL transition to GNTn the cycle after inN_valid && inN_sop && !out_almost_full; inN_ready SHALL be 0 in IDLE except for orphan draining (REQ-018).
REQ-014 When both inputs request in IDLE, the FSM SHALL grant the input that is not last_grant (round-robin); last_grant resets to 1, so in0 wins the first tie.
REQ-015 In GNTn, inN_ready SHALL equal (!out_valid || out_ready); the other input's ready SHALL be 0.
REQ-016 In GNTn, acceptance of a beat with inN_eop SHALL cause the following transitions:
  - FSM returns to IDLE;
  - last_grant is set to n;
  - a beat with sop && eop both set is a one-beat packet.
REQ-017 The output SHALL be a single register stage, with the following behaviour:
  - an accepted input beat appears on out_* on the next cycle (latency 1);
  - out_* is held stable while out_valid && !out_ready;
  - full throughput of 1 beat/cycle when out_ready is held high.
REQ-018 In IDLE, a beat with inN_valid && !inN_sop is an orphan and SHALL be handled as follows:
  - inN_ready is driven 1 and the beat is discarded, never forwarded;
  - err_cnt is incremented by 1, saturating at 16'hFFFF;
  - simultaneous orphans on both inputs increment err_cnt by 2, still saturating.
REQ-019 In GNTn, a beat carrying sop before the current packet's eop SHALL be forwarded unchanged as data, with no state change.
REQ-020 out_almost_full rising mid-packet SHALL NOT stall the granted packet; only out_ready throttles it.
REQ-021 out_empty SHALL be forwarded unmodified and is meaningful only on eop beats.
REQ-022 The FSM SHALL return to IDLE for a new grant decision after every eop; no back-to-back grant is made in the same cycle as the eop, giving a 1-cycle bubble per packet.

Reset
REQ-023 On rst, the block SHALL immediately clear all state and outputs:
  - state=IDLE, last_grant=1, err_cnt=0;
  - out_valid=0, out_sop=0, out_eop=0;
  - out_data=0, out_empty=0, out_channel=0;
  - in0_ready=0, in1_ready=0.
REQ-024 Reset mid-packet SHALL abandon the packet without emitting eop; after deassertion, the first beat granted SHALL be an sop beat.

Configuration
REQ-025 With macro AVL_STREAM_PKT_ARB_CHTAG_EN defined, out_channel SHALL be driven with the source input index (0 or 1), zero-extended to NUM bits; inN_channel is ignored.
REQ-026 Without AVL_STREAM_PKT_ARB_CHTAG_EN, out_channel SHALL pass inN_channel through unmodified from the granted input.

Verification
REQ-027 Scenario: single in0 3-beat packet (D0 sop, D1, D2 eop, empty=5), out_ready=1 -> out beats D0..D2 appear one cycle after each accept, with eop and empty=5 on D2.
REQ-028 Scenario: in0 and in1 both present sop in IDLE after reset -> in0 granted first, in1 next; with both continuously requesting, grants alternate 0,1,0,1.
REQ-029 Scenario: during an in1 4-beat packet, out_ready is toggled 1,0,0,1 -> out_* held stable while stalled, no beat lost or duplicated, in0_ready=0 throughout.
REQ-030 Scenario: out_almost_full=1 in IDLE with in0 sop pending -> no grant; deassert -> GNT0 next cycle. Separately, almost_full asserted mid-packet -> packet completes.
REQ-031 Scenario: in1 non-sop beat in IDLE, err_cnt preset at 16'hFFFE -> beat dropped and err_cnt=16'hFFFF; a second orphan leaves err_cnt at 16'hFFFF.
REQ-032 Scenario: rst asserted after beat 2 of a 5-beat packet -> outputs zero asynchronously; after release, the next out beat has sop=1. With CHTAG_EN defined, an in1 packet shows out_channel=1.
